left_shift_2bits_32: RTL and testbench

- Fixed left-shift-by-2 unit for 33-bit operands, used ahead of the branch/jump adder (word offset to byte offset).
- Provides two views of the same shift:
  - a purely combinational output `out`, with zero latency;
  - a one-stage registered output with valid/ready flow control, the two bits shifted off the top, and a sticky overflow flag.

---
 rtl/left_shift_2bits_32_pkg.sv | 20 ++
 rtl/left_shift_2bits_32_shl_stage_reg.sv | 49 ++++
 rtl/left_shift_2bits_32.sv | 74 +++++++
 tb/tb_left_shift_2bits_32.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/left_shift_2bits_32_pkg.sv
// rtl/left_shift_2bits_32_pkg.sv - shared constants and fixed-shift helper
// Purpose: default operand width / shift amount and shl_fixed(), which packs
//          {shifted, lost} so the combinational path and the register stage
//          load are guaranteed to use the same shift.
package left_shift_2bits_32_pkg;

  localparam int SHL_WIDTH = 33;
  localparam int SHL_SHAMT = 2;

  // Upper SHL_WIDTH bits: value << SHL_SHAMT (truncated to SHL_WIDTH).
  // Lower SHL_SHAMT bits: the bits shifted off the top.
  function automatic logic [SHL_WIDTH+SHL_SHAMT-1:0] shl_fixed(
    input logic [SHL_WIDTH-1:0] value
  );
    return {value[SHL_WIDTH-SHL_SHAMT-1:0],
            {SHL_SHAMT{1'b0}},
            value[SHL_WIDTH-1:SHL_WIDTH-SHL_SHAMT]};
  endfunction

endpackage

// File: rtl/left_shift_2bits_32_shl_stage_reg.sv
// rtl/left_shift_2bits_32_shl_stage_reg.sv - one-entry valid/ready register stage
// Purpose: generic single-slot pipeline register with full throughput.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears data and valid)
//   in_data    DW-bit payload offered by the producer
//   in_valid   producer has a payload this cycle
//   in_ready   stage can take a payload this cycle
//   out_data   registered payload
//   out_valid  out_data holds a payload
//   out_ready  consumer takes out_data this cycle
module shl_stage_reg #(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic xfer;

  // Empty, or being drained this cycle: the slot frees up at the same edge.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      // Data only moves on a transfer, so garbage on in_data while
      // in_valid is low never reaches out_data.
      if (xfer) begin
        out_data <= in_data;
      end
      if (xfer) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/left_shift_2bits_32.sv
// rtl/left_shift_2bits_32.sv - fixed left-shift-by-2 unit, comb and registered views
// Purpose: word-to-byte offset shift ahead of the branch/jump adder.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in          WIDTH-bit operand
//   out         combinational in << SHAMT
//   in_valid    operand is a transfer request
//   in_ready    register stage can accept this cycle
//   out_q       registered shifted operand
//   lost_q      registered bits shifted off the top
//   out_valid   out_q / lost_q are valid
//   out_ready   consumer accepts out_q this cycle
//   ovf_sticky  some accepted operand had nonzero lost bits
//   ovf_clr     synchronous clear of ovf_sticky (a same-cycle set wins)
module left_shift_2bits_32
  import left_shift_2bits_32_pkg::*;
#(
  // Must match the package defaults: shl_fixed() is sized by them.
  parameter int WIDTH = SHL_WIDTH,
  parameter int SHAMT = SHL_SHAMT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [SHAMT-1:0] lost_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic [WIDTH+SHAMT-1:0] shl_res;
  logic [WIDTH+SHAMT-1:0] stage_q;
  logic [SHAMT-1:0]       lost;
  logic                   xfer;

  assign shl_res = shl_fixed(in);
  assign out     = shl_res[WIDTH+SHAMT-1:SHAMT];
  assign lost    = shl_res[SHAMT-1:0];

  shl_stage_reg #(
    .DW(WIDTH + SHAMT)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_data   (shl_res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (stage_q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_q  = stage_q[WIDTH+SHAMT-1:SHAMT];
  assign lost_q = stage_q[SHAMT-1:0];

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (xfer && (|lost)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_left_shift_2bits_32.sv
// tb/tb_left_shift_2bits_32.sv - directed and randomised checks for left_shift_2bits_32
module tb_left_shift_2bits_32;

  logic        clk;
  logic        rst;
  logic [32:0] in_op;
  logic [32:0] out;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] out_q;
  logic [1:0]  lost_q;
  logic        out_valid;
  logic        out_ready;
  logic        ovf_sticky;
  logic        ovf_clr;

  int total;
  int bad;

  left_shift_2bits_32 dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_op),
    .out        (out),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_q      (out_q),
    .lost_q     (lost_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle 1ns past it before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [32:0] sb_q[$];
  logic [32:0] op;
  logic [32:0] head;
  logic [32:0] exp_sh;
  logic        exp_rdy;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_op = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check("rst_out_q", out_q, 33'h0);
    check("rst_lost_q", lost_q, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ovf", ovf_sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Combinational path, no clock edge involved.
    in_op = 33'h1;
    #1 check("comb_1", out, 33'h4);
    in_op = 33'h2;
    #1 check("comb_2", out, 33'h8);
    in_op = 33'h1_FFFF_FFFF;
    #1 check("comb_top", out, 33'h1_FFFF_FFFC);

    cycle();
    rst = 1'b0;

    // Single transfer with lost = 2'b10.
    in_op = 33'h1_0000_0001; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    check("xfer_out_q", out_q, 33'h4);
    check("xfer_lost_q", lost_q, 2'b10);
    check("xfer_valid", out_valid, 1'b1);
    check("xfer_ovf", ovf_sticky, 1'b1);

    // Drain with junk on in, plus a clear.
    in_op = 33'h1_2345_6789; in_valid = 1'b0; ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("drain_valid", out_valid, 1'b0);
    check("drain_hold_q", out_q, 33'h4);
    check("clr_ovf", ovf_sticky, 1'b0);

    // Backpressure.
    in_op = 33'h3; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    check("bp_load_q", out_q, 33'hC);
    check("bp_load_valid", out_valid, 1'b1);
    in_op = 33'h7;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 1'b0);
      cycle();
      check("bp_hold_q", out_q, 33'hC);
      check("bp_hold_valid", out_valid, 1'b1);
    end
    in_op = 33'h5; out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1'b1);
    cycle();
    check("thru_q", out_q, 33'h14);
    check("thru_valid", out_valid, 1'b1);
    check("thru_ovf", ovf_sticky, 1'b0);

    // Load something with overflow, then asynchronous reset mid-cycle.
    in_op = 33'h1_8000_0003;
    cycle();
    check("pre_rst_q", out_q, 33'hC);
    check("pre_rst_lost", lost_q, 2'b11);
    check("pre_rst_ovf", ovf_sticky, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_q", out_q, 33'h0);
    check("arst_lost", lost_q, 2'b00);
    check("arst_ovf", ovf_sticky, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    in_op = 33'h9; in_valid = 1'b1;
    cycle();
    check("rst_no_xfer", out_valid, 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1 check("post_rst_ready", in_ready, 1'b1);
    cycle();

    // Set beats clear in the same cycle (lost = 2'b01).
    in_op = 33'h0_8000_0001; in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b1;
    cycle();
    check("setwin_ovf", ovf_sticky, 1'b1);
    check("setwin_q", out_q, 33'h4);
    check("setwin_lost", lost_q, 2'b01);
    in_valid = 1'b0;
    cycle();
    ovf_clr = 1'b0;
    check("clr_alone_ovf", ovf_sticky, 1'b0);

    // Random traffic against an in-order scoreboard.
    for (int i = 0; i < 1000; i++) begin
      op = {$urandom_range(1, 0) == 1, $urandom()};
      in_op = op;
      in_valid = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      exp_rdy = (sb_q.size() == 0) || out_ready;
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_out_valid", out_valid, sb_q.size() != 0);
      if (sb_q.size() != 0 && out_ready) begin
        head = sb_q.pop_front();
        exp_sh = head << 2;
        check("rnd_out_q", out_q, exp_sh);
        check("rnd_lost_q", lost_q, head[32:31]);
      end
      if (in_valid && exp_rdy) sb_q.push_back(op);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (sb_q.size() != 0) begin
        head = sb_q.pop_front();
        exp_sh = head << 2;
        check("tail_out_q", out_q, exp_sh);
        check("tail_lost_q", lost_q, head[32:31]);
      end
      cycle();
    end
    check("tail_empty", sb_q.size(), 0);
    check("tail_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
